// File: rtl/systolic_skew_feeder_if.sv
// Operand-load handshake and skewed stream bus for systolic_skew_feeder.
// The master side loads vectors and observes the stream; the slave side is the feeder.
interface systolic_skew_feeder_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 4
);

  logic                    flush_i;
  logic                    vec_valid_i;
  logic                    vec_ready_o;
  logic [N*DATA_WIDTH-1:0] vec_i;
  logic [N*DATA_WIDTH-1:0] data_o;
  logic                    valid_o;
  logic                    done_o;
  logic                    busy_o;

  // Producer of operand vectors and consumer of the skewed stream
  modport master (
    output flush_i,
    output vec_valid_i,
    output vec_i,
    input  vec_ready_o,
    input  data_o,
    input  valid_o,
    input  done_o,
    input  busy_o
  );

  // The feeder itself
  modport slave (
    input  flush_i,
    input  vec_valid_i,
    input  vec_i,
    output vec_ready_o,
    output data_o,
    output valid_o,
    output done_o,
    output busy_o
  );

endinterface

// File: rtl/systolic_skew_feeder.sv
// Edge feeder for a PE systolic array: buffers an N x N operand block as N
// vectors, then streams it into one array edge with a diagonal skew where
// lane i lags lane 0 by i cycles and carries zero outside its window.
module systolic_skew_feeder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 4
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  systolic_skew_feeder_if.slave bus
);

  localparam int unsigned CW = $clog2(N) + 1;      // accept counter
  localparam int unsigned TW = $clog2(2 * N - 1);  // stream step counter
  localparam int unsigned AW = $clog2(N);          // mem row index
  localparam int unsigned VW = N * DATA_WIDTH;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [TW-1:0]         t_q;
  logic [DATA_WIDTH-1:0] mem_q [N][N];
  logic [VW-1:0]         data_q;
  logic                  valid_q;
  logic                  done_q;
  logic [VW-1:0]         skew_d;

  // Handshake status is a direct decode of the state
  assign bus.vec_ready_o = (state_q == S_LOAD);
  assign bus.busy_o      = (state_q != S_LOAD);

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.done_o  = done_q;

  // Diagonal selection: lane i shows row (t - i) while that row index is in range
  always_comb begin
    skew_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      if ((int'(t_q) >= i) && (int'(t_q) < i + int'(N))) begin
        skew_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[AW'(int'(t_q) - i)][AW'(i)];
      end
    end
  end

  // Load / stream / done sequencing with registered stream outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      t_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        for (int i = 0; i < int'(N); i++) begin
          mem_q[k][i] <= '0;
        end
      end
    end else if (bus.flush_i) begin
      // Abort wins over everything; buffered rows are simply left stale
      state_q <= S_LOAD;
      cnt_q   <= '0;
      t_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          data_q  <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          if (bus.vec_valid_i) begin
            for (int i = 0; i < int'(N); i++) begin
              mem_q[cnt_q[AW-1:0]][i] <= bus.vec_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (cnt_q == CW'(N - 1)) begin
              cnt_q   <= '0;
              t_q     <= '0;
              state_q <= S_STREAM;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end

        S_STREAM: begin
          data_q  <= skew_d;
          valid_q <= 1'b1;
          done_q  <= 1'b0;
          t_q     <= t_q + TW'(1);
          if (t_q == TW'(2 * N - 2)) begin
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          data_q  <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
          t_q     <= '0;
          state_q <= S_LOAD;
        end

        default: begin
          state_q <= S_LOAD;
          cnt_q   <= '0;
          t_q     <= '0;
          data_q  <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: N=4 main instance plus N=2 and
// N=8 instances, with a scoreboard of expected skewed stream steps.
module tb_systolic_skew_feeder;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(4)) b4 ();
  systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(2)) b2 ();
  systolic_skew_feeder_if #(.DATA_WIDTH(DW), .N(8)) b8 ();

  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(4)) dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(b4.slave));
  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(b2.slave));
  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(8)) dut8 (.clk_i(clk), .rst_ni(rst_n), .bus(b8.slave));

  int          n_cmp;
  int          n_err;
  logic [63:0] exp_q [$];
  logic [7:0]  blk [8][8];
  logic [7:0]  lane0 [7];
  logic [7:0]  lane3 [7];
  logic [7:0]  lane0_ref [7];
  logic [7:0]  lane3_ref [7];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [63:0] vec, input logic fl);
    case (w)
      2: begin b2.vec_valid_i = v; b2.vec_i = 16'(vec); b2.flush_i = fl; end
      8: begin b8.vec_valid_i = v; b8.vec_i = vec;      b8.flush_i = fl; end
      default: begin b4.vec_valid_i = v; b4.vec_i = 32'(vec); b4.flush_i = fl; end
    endcase
  endtask

  task automatic get_out(input int w, output logic [63:0] d, output logic v,
                         output logic dn, output logic rdy, output logic bsy);
    case (w)
      2: begin d = 64'(b2.data_o); v = b2.valid_o; dn = b2.done_o; rdy = b2.vec_ready_o; bsy = b2.busy_o; end
      8: begin d = b8.data_o;      v = b8.valid_o; dn = b8.done_o; rdy = b8.vec_ready_o; bsy = b8.busy_o; end
      default: begin d = 64'(b4.data_o); v = b4.valid_o; dn = b4.done_o; rdy = b4.vec_ready_o; bsy = b4.busy_o; end
    endcase
  endtask

  function automatic logic [63:0] row(input int n, input int k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*8 +: 8] = blk[k][i];
    return r;
  endfunction

  task automatic rand_block(input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < n; i++)
        blk[k][i] = 8'($urandom_range(1, 255));
  endtask

  // Reference skew: step t, lane i holds row (t-i) of the block when in range
  task automatic push_model(input int n);
    logic [63:0] e;
    for (int t = 0; t < 2 * n - 1; t++) begin
      e = '0;
      for (int i = 0; i < n; i++) begin
        if (t - i >= 0 && t - i < n) e[i*8 +: 8] = blk[t - i][i];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic load_block(input int w, input int n);
    for (int k = 0; k < n; k++) begin
      set_in(w, 1'b1, row(n, k), 1'b0);
      cyc();
    end
    set_in(w, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic check_steps(input int w, input int steps, input bit bp, input string tag);
    logic [63:0] d, e;
    logic v, dn, rdy, bsy;
    for (int s = 0; s < steps; s++) begin
      if (bp) set_in(w, 1'b1, {$urandom(), $urandom()}, 1'b0);
      cyc();
      get_out(w, d, v, dn, rdy, bsy);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
      chk($sformatf("%s_data_s%0d", tag, s), d, e);
      chk($sformatf("%s_valid_s%0d", tag, s), 64'(v), 64'(1));
      chk($sformatf("%s_ready_s%0d", tag, s), 64'(rdy), 64'(0));
      if (w == 4 && s < 7) begin
        lane0[s] = d[7:0];
        lane3[s] = d[31:24];
      end
    end
  endtask

  task automatic check_done(input int w, input string tag);
    logic [63:0] d;
    logic v, dn, rdy, bsy;
    cyc();
    get_out(w, d, v, dn, rdy, bsy);
    chk({tag, "_done"},  64'(dn),  64'(1));
    chk({tag, "_valid"}, 64'(v),   64'(0));
    chk({tag, "_data"},  d,        64'(0));
    chk({tag, "_ready"}, 64'(rdy), 64'(1));
    chk({tag, "_busy"},  64'(bsy), 64'(0));
  endtask

  initial begin
    logic [63:0] d;
    logic v, dn, rdy, bsy;
    int pat [7];
    int k;

    n_cmp = 0;
    n_err = 0;
    lane0_ref = '{8'd1, 8'd11, 8'd21, 8'd31, 8'd0, 8'd0, 8'd0};
    lane3_ref = '{8'd0, 8'd0, 8'd0, 8'd4, 8'd14, 8'd24, 8'd34};
    pat = '{1, 0, 0, 1, 1, 0, 1};

    // Reset state
    rst_n = 1'b0;
    set_in(4, 1'b0, 64'h0, 1'b0);
    set_in(2, 1'b0, 64'h0, 1'b0);
    set_in(8, 1'b0, 64'h0, 1'b0);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    get_out(4, d, v, dn, rdy, bsy);
    chk("rst_data",  d,        64'(0));
    chk("rst_valid", 64'(v),   64'(0));
    chk("rst_done",  64'(dn),  64'(0));
    chk("rst_ready", 64'(rdy), 64'(1));
    chk("rst_busy",  64'(bsy), 64'(0));

    // Basic skew: element (k,i) = 10k+i+1
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++)
        blk[r][i] = 8'(10 * r + i + 1);
    push_model(4);
    load_block(4, 4);
    get_out(4, d, v, dn, rdy, bsy);
    chk("basic_e0_busy",  64'(bsy), 64'(1));
    chk("basic_e0_ready", 64'(rdy), 64'(0));
    chk("basic_e0_valid", 64'(v),   64'(0));
    check_steps(4, 7, 1'b0, "basic");
    for (int s = 0; s < 7; s++) begin
      chk($sformatf("basic_lane0_s%0d", s), 64'(lane0[s]), 64'(lane0_ref[s]));
      chk($sformatf("basic_lane3_s%0d", s), 64'(lane3[s]), 64'(lane3_ref[s]));
    end
    check_done(4, "basic_end");
    cyc();
    get_out(4, d, v, dn, rdy, bsy);
    chk("basic_done_once", 64'(dn), 64'(0));

    // Gapped load of the same block; garbage offered while valid is low
    k = 0;
    for (int p = 0; p < 7; p++) begin
      if (pat[p] != 0) begin
        set_in(4, 1'b1, row(4, k), 1'b0);
        k++;
      end else begin
        set_in(4, 1'b0, 64'hFFFF_FFFF, 1'b0);
      end
      cyc();
      if (p == 5) begin
        get_out(4, d, v, dn, rdy, bsy);
        chk("gap_still_loading", 64'(bsy), 64'(0));
      end
    end
    set_in(4, 1'b0, 64'h0, 1'b0);
    push_model(4);
    check_steps(4, 7, 1'b0, "gap");
    check_done(4, "gap_end");

    // Backpressure: valid held high with fresh data throughout the stream
    rand_block(4);
    push_model(4);
    load_block(4, 4);
    check_steps(4, 7, 1'b1, "bp");
    rand_block(4);
    set_in(4, 1'b1, row(4, 0), 1'b0);
    check_done(4, "bp_end");
    cyc();
    get_out(4, d, v, dn, rdy, bsy);
    chk("bp_next_v0_accepted", 64'(bsy), 64'(0));
    for (int r = 1; r < 4; r++) begin
      set_in(4, 1'b1, row(4, r), 1'b0);
      cyc();
    end
    set_in(4, 1'b0, 64'h0, 1'b0);
    push_model(4);
    check_steps(4, 7, 1'b0, "bp_next");
    check_done(4, "bp_next_end");

    // Flush at stream step 3, with a vector offered in the same cycle
    rand_block(4);
    push_model(4);
    load_block(4, 4);
    check_steps(4, 4, 1'b0, "fl");
    set_in(4, 1'b1, 64'hA5A5_A5A5, 1'b1);
    cyc();
    set_in(4, 1'b0, 64'h0, 1'b0);
    get_out(4, d, v, dn, rdy, bsy);
    chk("fl_data",  d,        64'(0));
    chk("fl_valid", 64'(v),   64'(0));
    chk("fl_done",  64'(dn),  64'(0));
    chk("fl_ready", 64'(rdy), 64'(1));
    cyc();
    get_out(4, d, v, dn, rdy, bsy);
    chk("fl_no_done", 64'(dn), 64'(0));
    exp_q.delete();

    // Flush during a partial load resets the accept count
    rand_block(4);
    set_in(4, 1'b1, row(4, 0), 1'b0); cyc();
    set_in(4, 1'b1, row(4, 1), 1'b0); cyc();
    set_in(4, 1'b1, 64'h5A5A_5A5A, 1'b1); cyc();
    set_in(4, 1'b0, 64'h0, 1'b0);
    rand_block(4);
    push_model(4);
    load_block(4, 4);
    check_steps(4, 7, 1'b0, "fl_fresh");
    check_done(4, "fl_fresh_end");

    // Asynchronous reset at stream step 2, checked before any clock edge
    rand_block(4);
    push_model(4);
    load_block(4, 4);
    check_steps(4, 3, 1'b0, "arst");
    #2 rst_n = 1'b0;
    #1;
    get_out(4, d, v, dn, rdy, bsy);
    chk("arst_data",  d,        64'(0));
    chk("arst_valid", 64'(v),   64'(0));
    chk("arst_done",  64'(dn),  64'(0));
    chk("arst_ready", 64'(rdy), 64'(1));
    chk("arst_busy",  64'(bsy), 64'(0));
    exp_q.delete();
    #1 rst_n = 1'b1;
    cyc();
    get_out(4, d, v, dn, rdy, bsy);
    chk("arst_after_valid", 64'(v), 64'(0));
    chk("arst_after_busy",  64'(bsy), 64'(0));

    // Parameter sweep: N = 2 and N = 8 with random data
    rand_block(2);
    push_model(2);
    load_block(2, 2);
    check_steps(2, 3, 1'b0, "n2");
    check_done(2, "n2_end");

    rand_block(8);
    push_model(8);
    load_block(8, 8);
    check_steps(8, 15, 1'b0, "n8");
    check_done(8, "n8_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Edge feeder for the PE systolic array. It buffers an N×N operand block as N vectors, one vector per accepted transfer. It then streams the block into one edge of the array (the left edge or the top edge) with the diagonal skew the PEs require: lane i is delayed i cycles, and zeros are emitted outside each lane's active window. Two instances feed one array, one for the row operand and one for the column operand.

## Interface
- DATA_WIDTH, 32, width of one operand element (matches the PE operand width)
- N, 4, number of lanes, equal to the array dimension; N ≥ 2
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous reset, active low
- flush_i  in  1  synchronous abort; returns the block to LOAD and discards the buffer
- vec_valid_i  in  1  an input vector is offered
- vec_ready_o  out  1  the block can accept a vector; combinational, equals (state == LOAD)
- vec_i  in  N*DATA_WIDTH  input vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- data_o  out  N*DATA_WIDTH  skewed lane outputs, registered; lane i drives the array edge PE i
- valid_o  out  1  registered; high while data_o carries a stream step
- done_o  out  1  registered one-cycle pulse after the last stream step
- busy_o  out  1  combinational, equals (state != LOAD)

## Operation
- Storage: mem[k][i] for k, i in 0..N-1, N*N*DATA_WIDTH flops. Vector k is the k-th accepted vector.
- Accept counter cnt has width clog2(N)+1. Step counter t has width clog2(2N-1).
- States: LOAD, STREAM, DONE.
- LOAD:
  - On vec_valid_i && vec_ready_o, write mem[cnt] <= vec_i and increment cnt.
  - When the accepted vector is number N-1: cnt <= 0, t <= 0, state <= STREAM.
  - data_o holds 0. valid_o = 0. done_o <= 0.
- STREAM, on each edge:
  - Lane i: data_o[i] <= mem[t-i][i] if 0 ≤ t-i ≤ N-1, else 0.
  - valid_o <= 1. t <= t+1.
  - If t == 2N-2: state <= DONE.
  - vec_valid_i is ignored because ready = 0.
- DONE, one edge:
  - data_o <= 0, valid_o <= 0, done_o <= 1, state <= LOAD.
- flush_i:
  - Takes priority over every other action in every state.
  - On the edge where it is sampled: state <= LOAD, cnt <= 0, t <= 0, data_o <= 0, valid_o <= 0, done_o <= 0.
  - A vector offered in the same cycle is not written.
  - mem contents need not be cleared.
- Reset (asynchronous, any state, including mid-stream):
  - state = LOAD, cnt = 0, t = 0, data_o = 0, valid_o = 0, done_o = 0.
  - mem is cleared to 0.
- No arithmetic on data. Elements pass through bit-exact. The zero padding is what lets the PEs accumulate a product of 0 outside each window.

## Timing
- Reset values: vec_ready_o = 1, busy_o = 0, data_o = 0, valid_o = 0, done_o = 0.
- E0 is the edge that accepts vector N-1.
  - Step t appears on data_o after edge E0+1+t, for t = 0..2N-2.
  - valid_o is high for exactly 2N-1 consecutive cycles.
  - Latency from the last accept to the first stream output is 1 cycle.
- Lane i carries a non-zero element only during steps i..i+N-1. Lane 0 leads and lane N-1 trails by N-1 cycles.
- At edge E0+2N: data_o = 0, valid_o = 0, done_o = 1 for one cycle, and vec_ready_o returns high in the same cycle.
  - A vector offered in that cycle is accepted as vector 0 of the next block.
- Vectors may arrive with gaps; cnt holds while vec_valid_i = 0.
- Back-to-back throughput: one block per N + 2N cycles minimum (N load + 2N-1 stream + 1 done).

## Test plan
Tests run with N = 4 and DATA_WIDTH = 8 unless stated otherwise.
- Reset state: hold rst_ni low, then release -> data_o = 0, valid_o = 0, done_o = 0, vec_ready_o = 1, busy_o = 0.
- Basic skew: load 4 vectors back to back with lane i of vector k = 10k+i+1 ->
  - Lane 0 outputs 1, 11, 21, 31, 0, 0, 0.
  - Lane 3 outputs 0, 0, 0, 4, 14, 24, 34.
  - valid_o is high for 7 cycles, then done_o pulses once and vec_ready_o = 1.
- Gapped load: vec_valid_i toggles 1, 0, 0, 1, 1, 0, 1 -> exactly 4 vectors are accepted, and the stream is identical to basic skew.
- Backpressure: hold vec_valid_i = 1 with new data every cycle during STREAM -> nothing is written and vec_ready_o = 0. Vector 0 of the next block is accepted in the done_o cycle.
- Flush mid-stream: assert flush_i at step 3 -> the next edge gives data_o = 0, valid_o = 0, and no done_o. A fresh 4-vector load then streams the new data correctly.
- Async reset mid-stream: pull rst_ni low at step 2 -> all outputs are 0 immediately, without waiting for a clock edge, and the state is LOAD. Parameter sweep: N = 2 and N = 8, random data checked against a reference skew model.
